tt_um_mvm_ctrl: RTL and testbench

Sequencer for the ternary matrix-vector engine: drives the weight loader through one full load, then walks the output rows of the combinational ternary dot-product datapath. Each row result is returned through a one-entry valid/ready output register. Sits between the top-level pin decoder and the loader/MAC datapath; owns the load enable, the loader clear and the row select.

---
 rtl/tt_ternary_pkg.sv | 23 ++
 rtl/tt_um_out_slot.sv | 52 +++++
 rtl/tt_um_mvm_ctrl.sv | 141 ++++++++++++++
 tb/tb_tt_um_mvm_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_ternary_pkg.sv
// Shared types and default sizing for the ternary matrix-vector engine.
package tt_ternary_pkg;

    localparam int unsigned DEF_MAX_IN_LEN  = 16;
    localparam int unsigned DEF_MAX_OUT_LEN = 8;
    localparam int unsigned DEF_WIDTH       = 2;
    localparam int unsigned DEF_WIDTH_BITS  = $clog2(DEF_WIDTH);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        LOAD    = 3'd2,
        SETTLE  = 3'd3,
        COMPUTE = 3'd4,
        DRAIN   = 3'd5
    } state_t;

    // Signed accumulator width able to hold +/-in_len.
    function automatic int unsigned acc_width_f(input int unsigned in_len);
        return $clog2(in_len) + 2;
    endfunction

endpackage

// File: rtl/tt_um_out_slot.sv
// One-entry valid/ready holding register for row results.
module tt_um_out_slot
    import tt_ternary_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = 6,
    parameter int unsigned ROW_BITS  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_ena,
    input  logic                 i_clr,
    input  logic                 i_load,
    input  logic [ACC_WIDTH-1:0] i_data,
    input  logic [ROW_BITS-1:0]  i_row,
    input  logic                 i_ready,
    output logic [ACC_WIDTH-1:0] o_data,
    output logic [ROW_BITS-1:0]  o_row,
    output logic                 o_valid,
    output logic                 o_cap_c
);

    logic [ACC_WIDTH-1:0] r_data;
    logic [ROW_BITS-1:0]  r_row;
    logic                 r_valid;

    // Slot may take a new entry when empty or when the current one leaves this cycle.
    assign o_cap_c = !r_valid || i_ready;

    // Load has priority over pop so accept+capture in one cycle keeps valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_row   <= '0;
            r_valid <= 1'b0;
        end else if (i_ena) begin
            if (i_clr) begin
                r_valid <= 1'b0;
            end else if (i_load) begin
                r_data  <= i_data;
                r_row   <= i_row;
                r_valid <= 1'b1;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data  = r_data;
    assign o_row   = r_row;
    assign o_valid = r_valid;

endmodule

// File: rtl/tt_um_mvm_ctrl.sv
// Job sequencer: loader clear/load, settle, row walk and result handoff.
module tt_um_mvm_ctrl
    import tt_ternary_pkg::*;
#(
    parameter int unsigned MAX_IN_LEN   = DEF_MAX_IN_LEN,
    parameter int unsigned MAX_OUT_LEN  = DEF_MAX_OUT_LEN,
    parameter int unsigned ACC_WIDTH    = acc_width_f(MAX_IN_LEN),
    parameter int unsigned MAX_OUT_BITS = $clog2(MAX_OUT_LEN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    start,
    input  logic                    skip_load,
    input  logic [MAX_OUT_BITS-1:0] cfg_out_len,
    input  logic                    abort,
    output logic                    load_clr,
    output logic                    load_ena,
    input  logic                    load_done,
    output logic [MAX_OUT_BITS-1:0] mac_row,
    input  logic [ACC_WIDTH-1:0]    mac_result,
    output logic [ACC_WIDTH-1:0]    out_data,
    output logic [MAX_OUT_BITS-1:0] out_row,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [MAX_OUT_BITS-1:0] r_row;
    logic [MAX_OUT_BITS-1:0] w_row_nxt;
    logic [MAX_OUT_BITS-1:0] r_cfg;
    logic [MAX_OUT_BITS-1:0] w_cfg_nxt;
    logic                    r_load_clr;
    logic                    r_load_ena;
    logic                    r_busy;
    logic                    r_done;
    logic                    w_done_nxt;
    logic                    w_slot_load;
    logic                    w_slot_clr;
    logic                    w_cap;
    logic                    w_out_valid;

    // Next-state, row counter, config latch and slot controls.
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_cfg_nxt   = r_cfg;
        w_done_nxt  = 1'b0;
        w_slot_load = 1'b0;
        w_slot_clr  = 1'b0;
        if (abort) begin
            w_state_nxt = IDLE;
            w_slot_clr  = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_cfg_nxt   = cfg_out_len;
                        w_row_nxt   = '0;
                        w_state_nxt = skip_load ? COMPUTE : CLEAR;
                    end
                end
                CLEAR:  w_state_nxt = LOAD;
                LOAD: begin
                    if (load_done) w_state_nxt = SETTLE;
                end
                SETTLE: begin
                    w_row_nxt   = '0;
                    w_state_nxt = COMPUTE;
                end
                COMPUTE: begin
                    if (w_cap) begin
                        w_slot_load = 1'b1;
                        if (r_row == r_cfg) begin
                            w_state_nxt = DRAIN;
                        end else begin
                            w_row_nxt = r_row + MAX_OUT_BITS'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (w_out_valid && out_ready) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State and registered Moore outputs; everything holds while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_row      <= '0;
            r_cfg      <= '0;
            r_load_clr <= 1'b0;
            r_load_ena <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (ena) begin
            r_state    <= w_state_nxt;
            r_row      <= w_row_nxt;
            r_cfg      <= w_cfg_nxt;
            r_load_clr <= (w_state_nxt == CLEAR);
            r_load_ena <= (w_state_nxt == LOAD);
            r_busy     <= (w_state_nxt != IDLE);
            r_done     <= w_done_nxt;
        end
    end

    tt_um_out_slot #(
        .ACC_WIDTH (ACC_WIDTH),
        .ROW_BITS  (MAX_OUT_BITS)
    ) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_ena   (ena),
        .i_clr   (w_slot_clr),
        .i_load  (w_slot_load),
        .i_data  (mac_result),
        .i_row   (r_row),
        .i_ready (out_ready),
        .o_data  (out_data),
        .o_row   (out_row),
        .o_valid (w_out_valid),
        .o_cap_c (w_cap)
    );

    assign load_clr  = r_load_clr;
    assign load_ena  = r_load_ena;
    assign mac_row   = r_row;
    assign out_valid = w_out_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_tt_um_mvm_ctrl.sv
// Directed bench for the matrix-vector sequencer with a loader and datapath model.
module tb_tt_um_mvm_ctrl;

    localparam int unsigned AW = 6;
    localparam int unsigned RB = 3;
    localparam int unsigned WD = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic          start;
    logic          skip_load;
    logic [RB-1:0] cfg_out_len;
    logic          abort;
    logic          load_clr;
    logic          load_ena;
    logic          load_done;
    logic [RB-1:0] mac_row;
    logic [AW-1:0] mac_result;
    logic [AW-1:0] out_data;
    logic [RB-1:0] out_row;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;
    int ld_cnt = 0;
    int job_cfg = 0;

    always #5 clk = ~clk;

    tt_um_mvm_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .start       (start),
        .skip_load   (skip_load),
        .cfg_out_len (cfg_out_len),
        .abort       (abort),
        .load_clr    (load_clr),
        .load_ena    (load_ena),
        .load_done   (load_done),
        .mac_row     (mac_row),
        .mac_result  (mac_result),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done)
    );

    // Datapath model: row r yields 5*r-5 (row 0 gives -5).
    function automatic logic [AW-1:0] f_mac(input logic [RB-1:0] r);
        return AW'(5 * int'(r) - 5);
    endfunction

    assign mac_result = f_mac(mac_row);

    // Loader model: terminal count after (cfg+1)*WIDTH enabled cycles.
    always @(posedge clk) begin
        if (load_clr)      ld_cnt <= 0;
        else if (load_ena) ld_cnt <= ld_cnt + 1;
    end
    assign load_done = load_ena && (ld_cnt == (job_cfg + 1) * int'(WD) - 1);

    task automatic chk(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          start;
        logic          skip;
        logic [RB-1:0] cfg;
        logic          ready;
        logic          clr;
        logic          le;
        logic          bsy;
        logic          vld;
        logic [RB-1:0] orow;
        logic [RB-1:0] mrow;
        logic          dn;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic sk, input int c, input logic rd,
                                input logic cl, input logic le, input logic b, input logic v,
                                input int orw, input int mr, input logic d);
        vec_t x;
        x.start = s;  x.skip = sk; x.cfg = RB'(c); x.ready = rd;
        x.clr = cl;   x.le = le;   x.bsy = b;      x.vld = v;
        x.orow = RB'(orw); x.mrow = RB'(mr); x.dn = d;
        return x;
    endfunction

    vec_t tbl[17];

    initial begin
        logic [AW-1:0] m5;
        m5 = 6'b111011;

        // Full job, cfg_out_len=3: CLEAR, 8 LOAD, SETTLE, 4 rows, done.
        tbl[0] = mk(1, 0, 3, 1, 1, 0, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) tbl[i] = mk(0, 0, 3, 1, 0, 1, 1, 0, 0, 0, 0);
        tbl[9]  = mk(0, 0, 3, 1, 0, 0, 1, 0, 0, 0, 0);
        tbl[10] = mk(0, 0, 3, 1, 0, 0, 1, 0, 0, 0, 0);
        tbl[11] = mk(0, 0, 3, 1, 0, 0, 1, 1, 0, 1, 0);
        tbl[12] = mk(0, 0, 3, 1, 0, 0, 1, 1, 1, 2, 0);
        tbl[13] = mk(0, 0, 3, 1, 0, 0, 1, 1, 2, 3, 0);
        tbl[14] = mk(0, 0, 3, 1, 0, 0, 1, 1, 3, 3, 0);
        tbl[15] = mk(0, 0, 3, 1, 0, 0, 0, 0, 0, 3, 1);
        tbl[16] = mk(0, 0, 3, 1, 0, 0, 0, 0, 0, 3, 0);

        rst_n = 1'b0; ena = 1'b1; start = 1'b0; skip_load = 1'b0;
        cfg_out_len = '0; abort = 1'b0; out_ready = 1'b1;
        repeat (2) step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_ena", int'(load_ena), 0);
        chk("rst_clr", int'(load_clr), 0);
        chk("rst_row", int'(mac_row), 0);
        chk("rst_data", int'(out_data), 0);
        rst_n = 1'b1;
        step();

        job_cfg = 3;
        for (int i = 0; i < 17; i++) begin
            start = tbl[i].start; skip_load = tbl[i].skip;
            cfg_out_len = tbl[i].cfg; out_ready = tbl[i].ready;
            step();
            chk($sformatf("tbl%0d_clr", i), int'(load_clr), int'(tbl[i].clr));
            chk($sformatf("tbl%0d_lena", i), int'(load_ena), int'(tbl[i].le));
            chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].bsy));
            chk($sformatf("tbl%0d_valid", i), int'(out_valid), int'(tbl[i].vld));
            chk($sformatf("tbl%0d_mrow", i), int'(mac_row), int'(tbl[i].mrow));
            chk($sformatf("tbl%0d_done", i), int'(done), int'(tbl[i].dn));
            if (tbl[i].vld) begin
                chk($sformatf("tbl%0d_orow", i), int'(out_row), int'(tbl[i].orow));
                chk($sformatf("tbl%0d_data", i), int'(out_data), int'(f_mac(tbl[i].orow)));
            end
        end

        // Backpressure on row 1 plus ignored start/cfg while busy.
        job_cfg = 3; start = 1; skip_load = 1; cfg_out_len = 3; out_ready = 1;
        step();
        start = 0; skip_load = 0;
        chk("bp_lena", int'(load_ena), 0);
        chk("bp_clr", int'(load_clr), 0);
        chk("bp_m0", int'(mac_row), 0);
        step();
        chk("bp_r0", int'(out_row), 0);
        start = 1; cfg_out_len = 0;
        step();
        chk("bp_r1", int'(out_row), 1);
        start = 0; out_ready = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_hold_valid", int'(out_valid), 1);
            chk("bp_hold_row", int'(out_row), 1);
            chk("bp_hold_data", int'(out_data), int'(f_mac(3'd1)));
            chk("bp_hold_mrow", int'(mac_row), 2);
        end
        out_ready = 1;
        step();
        chk("bp_r2", int'(out_row), 2);
        chk("bp_d2", int'(out_data), int'(f_mac(3'd2)));
        step();
        chk("bp_r3", int'(out_row), 3);
        chk("bp_v3", int'(out_valid), 1);
        step();
        chk("bp_done", int'(done), 1);
        chk("bp_idle", int'(busy), 0);

        // Single-row job with resident weights.
        job_cfg = 0; start = 1; skip_load = 1; cfg_out_len = 0;
        step();
        start = 0; skip_load = 0;
        chk("sk_busy", int'(busy), 1);
        chk("sk_clr", int'(load_clr), 0);
        chk("sk_lena", int'(load_ena), 0);
        step();
        chk("sk_valid", int'(out_valid), 1);
        chk("sk_data", int'(out_data), int'(m5));
        chk("sk_row", int'(out_row), 0);
        chk("sk_lena2", int'(load_ena), 0);
        step();
        chk("sk_done", int'(done), 1);
        chk("sk_valid0", int'(out_valid), 0);

        // Abort on the third LOAD cycle, then restart re-clears the loader.
        job_cfg = 1; start = 1; cfg_out_len = 1;
        step();
        start = 0;
        chk("ab_clr", int'(load_clr), 1);
        step(); step(); step();
        chk("ab_lena3", int'(load_ena), 1);
        abort = 1;
        step();
        abort = 0;
        chk("ab_busy", int'(busy), 0);
        chk("ab_lena", int'(load_ena), 0);
        chk("ab_valid", int'(out_valid), 0);
        chk("ab_done", int'(done), 0);
        step();
        chk("ab_done2", int'(done), 0);
        start = 1;
        step();
        start = 0;
        chk("ab_reclr", int'(load_clr), 1);
        abort = 1;
        step();
        abort = 0;
        chk("ab_idle2", int'(busy), 0);

        // ena low for four cycles mid-COMPUTE.
        job_cfg = 3; start = 1; skip_load = 1; cfg_out_len = 3; out_ready = 1;
        step();
        start = 0; skip_load = 0;
        step();
        chk("en_r0", int'(out_row), 0);
        ena = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("en_hold_valid", int'(out_valid), 1);
            chk("en_hold_row", int'(out_row), 0);
            chk("en_hold_mrow", int'(mac_row), 1);
            chk("en_hold_busy", int'(busy), 1);
        end
        ena = 1;
        step();
        chk("en_r1", int'(out_row), 1);
        chk("en_m2", int'(mac_row), 2);
        step(); step();
        chk("en_r3", int'(out_row), 3);
        step();
        chk("en_done", int'(done), 1);

        // Async reset while DRAIN holds a result.
        job_cfg = 0; start = 1; skip_load = 1; cfg_out_len = 0; out_ready = 0;
        step();
        start = 0; skip_load = 0;
        step(); step();
        chk("rd_valid", int'(out_valid), 1);
        chk("rd_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rd_rst_valid", int'(out_valid), 0);
        chk("rd_rst_busy", int'(busy), 0);
        chk("rd_rst_data", int'(out_data), 0);
        chk("rd_rst_done", int'(done), 0);
        #1 rst_n = 1'b1;
        out_ready = 1;
        step();
        chk("rd_after_busy", int'(busy), 0);
        chk("rd_after_done", int'(done), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
